// File: rtl/tmr_wr_sched_if.sv
// Write-port bundle for the timer register scheduler: two requester ports,
// the overflow strobe, and the shared timer write port with pending flags.
interface tmr_wr_sched_if;
  logic       req0_valid;
  logic [1:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       ov_int;
  logic       wen;
  logic [3:0] addr3;
  logic [7:0] data_in;
  logic [1:0] pend;

  // Requester / timer side
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output ov_int,
    input  req0_ready, req1_ready,
    input  wen, addr3, data_in, pend
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  ov_int,
    output req0_ready, req1_ready,
    output wen, addr3, data_in, pend
  );
endinterface

// File: rtl/tmr_wr_sched.sv
// Round-robin scheduler for the timer's single write port. The duty-cycle
// updater's OCMP/PERIOD writes can be parked in shadow registers and
// committed on the next overflow edge so PWM changes never land mid-period.
module tmr_wr_sched #(
  parameter logic [1:0] PAGE     = 2'b10,
  parameter bit         SYNC_UPD = 1'b1
) (
  input  logic           tmrclk,
  input  logic           rst_n,
  tmr_wr_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    C_OCMP = 2'd1,
    C_PER  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       ov_q;
  logic       ov_rise;
  logic [1:0] pend_q;
  logic [1:0] pend_eff;
  logic [1:0] def_bit;
  logic [7:0] shadow1;
  logic [7:0] shadow3;
  logic       rr_last;

  logic       r0_rdy;
  logic       r1_rdy;
  logic       port_we;
  logic [1:0] port_idx;
  logic [7:0] port_data;
  logic       def_we;
  logic       rr_upd;
  logic       rr_win;
  logic       req1_defer;

  // OCMP (idx 1) and PERIOD (idx 3) are exactly the indices with bit 0 set.
  assign req1_defer = SYNC_UPD && bus.req1_addr[0];
  assign ov_rise    = bus.ov_int & ~ov_q;

  // A deferred write accepted in the overflow cycle joins that commit.
  assign def_bit  = def_we ? (bus.req1_addr[1] ? 2'b10 : 2'b01) : 2'b00;
  assign pend_eff = pend_q | def_bit;

  assign bus.req0_ready = r0_rdy;
  assign bus.req1_ready = r1_rdy;
  assign bus.pend       = pend_q;

  // State register: commit sequencer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge tmrclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: leave IDLE on an overflow edge when anything is pending.
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE: begin
        if (ov_rise && pend_eff[0])      state_nxt = C_OCMP;
        else if (ov_rise && pend_eff[1]) state_nxt = C_PER;
        else                             state_nxt = IDLE;
      end
      C_OCMP:  state_nxt = pend_q[1] ? C_PER : IDLE;
      C_PER:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: handshake, arbitration and the value to load into the write port.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    r0_rdy    = 1'b0;
    r1_rdy    = 1'b0;
    port_we   = 1'b0;
    port_idx  = 2'b00;
    port_data = 8'h00;
    def_we    = 1'b0;
    rr_upd    = 1'b0;
    rr_win    = rr_last;
    unique case (state)
      IDLE: begin
        if (bus.req1_valid && req1_defer) begin
          // Deferred accept leaves the port free for req0 in the same cycle.
          r1_rdy = 1'b1;
          def_we = 1'b1;
          if (bus.req0_valid) begin
            r0_rdy    = 1'b1;
            port_we   = 1'b1;
            port_idx  = bus.req0_addr;
            port_data = bus.req0_data;
          end
        end else if (bus.req0_valid && bus.req1_valid) begin
          // Contention: the requester that did not win last time goes now.
          rr_upd = 1'b1;
          rr_win = ~rr_last;
          if (rr_last) begin
            r0_rdy    = 1'b1;
            port_idx  = bus.req0_addr;
            port_data = bus.req0_data;
          end else begin
            r1_rdy    = 1'b1;
            port_idx  = bus.req1_addr;
            port_data = bus.req1_data;
          end
          port_we = 1'b1;
        end else if (bus.req0_valid) begin
          r0_rdy    = 1'b1;
          port_we   = 1'b1;
          port_idx  = bus.req0_addr;
          port_data = bus.req0_data;
        end else if (bus.req1_valid) begin
          r1_rdy    = 1'b1;
          port_we   = 1'b1;
          port_idx  = bus.req1_addr;
          port_data = bus.req1_data;
        end
      end
      C_OCMP: begin
        port_we   = 1'b1;
        port_idx  = 2'd1;
        port_data = shadow1;
      end
      C_PER: begin
        port_we   = 1'b1;
        port_idx  = 2'd3;
        port_data = shadow3;
      end
      default: ;
    endcase
  end

  // Registered timer write port; address/data hold their last value when idle.
  always_ff @(posedge tmrclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wen     <= 1'b0;
      bus.addr3   <= {PAGE, 2'b00};
      bus.data_in <= 8'h00;
    end else begin
      bus.wen <= port_we;
      if (port_we) begin
        bus.addr3   <= {PAGE, port_idx};
        bus.data_in <= port_data;
      end
    end
  end

  // Shadow registers and pending flags: set by deferred accepts, cleared by commit.
  // NOTE: the shadows are only two bytes, so they take the async reset like any flop.
  always_ff @(posedge tmrclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow1 <= 8'h00;
      shadow3 <= 8'h00;
      pend_q  <= 2'b00;
    end else begin
      if (def_we) begin
        if (bus.req1_addr[1]) begin
          shadow3   <= bus.req1_data;
          pend_q[1] <= 1'b1;
        end else begin
          shadow1   <= bus.req1_data;
          pend_q[0] <= 1'b1;
        end
      end
      if (state == C_OCMP) pend_q[0] <= 1'b0;
      if (state == C_PER)  pend_q[1] <= 1'b0;
    end
  end

  // Overflow edge detector and round-robin history.
  always_ff @(posedge tmrclk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q    <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      ov_q <= bus.ov_int;
      if (rr_upd) rr_last <= rr_win;
    end
  end

endmodule

// File: tb/tb_tmr_wr_sched.sv
// Directed bench for tmr_wr_sched: stimulus pushes expected timer writes into
// a queue, a negedge monitor pops and compares each wen cycle.
module tb_tmr_wr_sched;

  logic tmrclk = 1'b0;
  logic rst_n  = 1'b0;

  tmr_wr_sched_if bus ();

  tmr_wr_sched #(.PAGE(2'b10), .SYNC_UPD(1'b1)) dut (
    .tmrclk (tmrclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 tmrclk = ~tmrclk;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed write must match the oldest expected one.
  always @(negedge tmrclk) begin
    wr_t e;
    if (rst_n && bus.wen) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_wen: got addr3=%b data_in=%h, no write expected",
                 bus.addr3, bus.data_in);
      end else begin
        e = exp_q.pop_front();
        check("wen_addr3", 16'(bus.addr3), 16'(e.addr));
        check("wen_data", 16'(bus.data_in), 16'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge tmrclk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [1:0] a, input logic [7:0] d);
    bus.req0_valid = v;
    bus.req0_addr  = a;
    bus.req0_data  = d;
  endtask

  task automatic drive1(input logic v, input logic [1:0] a, input logic [7:0] d);
    bus.req1_valid = v;
    bus.req1_addr  = a;
    bus.req1_data  = d;
  endtask

  task automatic idle();
    drive0(1'b0, 2'd0, 8'h00);
    drive1(1'b0, 2'd0, 8'h00);
  endtask

  task automatic check_rdy(input string name, input logic r0, input logic r1);
    check({name, "_r0"}, 16'(bus.req0_ready), 16'(r0));
    check({name, "_r1"}, 16'(bus.req1_ready), 16'(r1));
  endtask

  logic [7:0] d0, d1;

  // Stimulus
  initial begin
    idle();
    bus.ov_int = 1'b0;

    // Reset state
    repeat (2) @(posedge tmrclk);
    #1;
    check("rst_wen", 16'(bus.wen), 16'(1'b0));
    check("rst_addr3", 16'(bus.addr3), 16'(4'b1000));
    check("rst_data", 16'(bus.data_in), 16'(8'h00));
    check("rst_pend", 16'(bus.pend), 16'(2'b00));
    check_rdy("rst", 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1) single req0 write, wen one cycle after accept
    step();
    drive0(1'b1, 2'd2, 8'h84);
    @(negedge tmrclk);
    check_rdy("t1", 1'b1, 1'b0);
    check("t1_wen_before", 16'(bus.wen), 16'(1'b0));
    push(4'b1010, 8'h84);
    step();
    idle();
    @(negedge tmrclk);
    check("t1_r0_after", 16'(bus.req0_ready), 16'(1'b0));

    // 2) contention, grants alternate 0,1,0,1 starting with req0
    d0 = 8'h10;
    d1 = 8'h20;
    step();
    drive0(1'b1, 2'd0, d0);
    drive1(1'b1, 2'd0, d1);
    for (int k = 0; k < 4; k++) begin
      @(negedge tmrclk);
      check_rdy("t2", (k % 2) == 0, (k % 2) == 1);
      if ((k % 2) == 0) push(4'b1000, d0);
      else              push(4'b1000, d1);
      step();
      if ((k % 2) == 0) begin d0 = d0 + 8'h1; drive0(1'b1, 2'd0, d0); end
      else              begin d1 = d1 + 8'h1; drive1(1'b1, 2'd0, d1); end
    end
    idle();
    @(negedge tmrclk);

    // 3) deferred OCMP write, committed after an overflow pulse
    step();
    drive1(1'b1, 2'd1, 8'h40);
    @(negedge tmrclk);
    check_rdy("t3", 1'b0, 1'b1);
    step();
    idle();
    @(negedge tmrclk);
    check("t3_pend_set", 16'(bus.pend), 16'(2'b01));
    step();
    bus.ov_int = 1'b1;
    push(4'b1001, 8'h40);
    step();
    bus.ov_int = 1'b0;
    step();
    @(negedge tmrclk);
    check("t3_pend_clr", 16'(bus.pend), 16'(2'b00));

    // 4) last-wins shadows, OCMP then PERIOD, requesters blocked during commit
    step();
    drive1(1'b1, 2'd1, 8'h20);
    step();
    drive1(1'b1, 2'd3, 8'hC0);
    step();
    drive1(1'b1, 2'd1, 8'h30);
    @(negedge tmrclk);
    check_rdy("t4_def", 1'b0, 1'b1);
    step();
    idle();
    @(negedge tmrclk);
    check("t4_pend", 16'(bus.pend), 16'(2'b11));
    step();
    bus.ov_int = 1'b1;
    push(4'b1001, 8'h30);
    push(4'b1011, 8'hC0);
    push(4'b1000, 8'h55);
    step();
    bus.ov_int = 1'b0;
    drive0(1'b1, 2'd0, 8'h55);
    drive1(1'b1, 2'd2, 8'h66);
    @(negedge tmrclk);
    check_rdy("t4_cocmp", 1'b0, 1'b0);
    step();
    @(negedge tmrclk);
    check_rdy("t4_cper", 1'b0, 1'b0);
    step();
    @(negedge tmrclk);
    check_rdy("t4_resume", 1'b1, 1'b0);
    step();
    drive0(1'b0, 2'd0, 8'h00);
    push(4'b1010, 8'h66);
    @(negedge tmrclk);
    check_rdy("t4_r1_alone", 1'b0, 1'b1);
    step();
    idle();
    @(negedge tmrclk);
    check("t4_pend_clr", 16'(bus.pend), 16'(2'b00));

    // 5) overflow held high for 3 cycles -> one commit only
    step();
    drive1(1'b1, 2'd1, 8'h77);
    step();
    idle();
    bus.ov_int = 1'b1;
    push(4'b1001, 8'h77);
    repeat (3) step();
    bus.ov_int = 1'b0;
    repeat (4) step();
    @(negedge tmrclk);
    check("t5_pend", 16'(bus.pend), 16'(2'b00));

    // deferred PERIOD write in the same cycle as the overflow edge
    step();
    drive1(1'b1, 2'd3, 8'h99);
    bus.ov_int = 1'b1;
    push(4'b1011, 8'h99);
    @(negedge tmrclk);
    check_rdy("t7", 1'b0, 1'b1);
    step();
    idle();
    bus.ov_int = 1'b0;
    @(negedge tmrclk);
    check("t7_pend_per", 16'(bus.pend), 16'(2'b10));
    step();
    @(negedge tmrclk);
    check("t7_pend_clr", 16'(bus.pend), 16'(2'b00));

    // req0 immediate OCMP alongside a req1 deferred OCMP
    step();
    drive0(1'b1, 2'd1, 8'hAA);
    drive1(1'b1, 2'd1, 8'hBB);
    push(4'b1001, 8'hAA);
    @(negedge tmrclk);
    check_rdy("t8", 1'b1, 1'b1);
    step();
    idle();
    @(negedge tmrclk);
    check("t8_pend_kept", 16'(bus.pend), 16'(2'b01));
    step();
    bus.ov_int = 1'b1;
    push(4'b1001, 8'hBB);
    step();
    bus.ov_int = 1'b0;
    step();
    @(negedge tmrclk);
    check("t8_pend_clr", 16'(bus.pend), 16'(2'b00));

    // 6) reset during C_OCMP kills the commit
    step();
    drive1(1'b1, 2'd1, 8'h5A);
    step();
    drive1(1'b1, 2'd3, 8'hA5);
    step();
    idle();
    bus.ov_int = 1'b1;
    step();
    bus.ov_int = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_wen", 16'(bus.wen), 16'(1'b0));
    check("t6_pend", 16'(bus.pend), 16'(2'b00));
    step();
    step();
    rst_n = 1'b1;
    step();
    bus.ov_int = 1'b1;
    step();
    bus.ov_int = 1'b0;
    repeat (3) step();
    @(negedge tmrclk);
    check("t6_pend_after", 16'(bus.pend), 16'(2'b00));
    check("t6_addr3_after", 16'(bus.addr3), 16'(4'b1000));
    check("t6_data_after", 16'(bus.data_in), 16'(8'h00));

    // asynchronous reset while wen is high
    step();
    drive0(1'b1, 2'd0, 8'hC3);
    push(4'b1000, 8'hC3);
    step();
    idle();
    @(negedge tmrclk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_wen", 16'(bus.wen), 16'(1'b0));
    check("async_data", 16'(bus.data_in), 16'(8'h00));
    step();
    rst_n = 1'b1;
    repeat (2) step();

    check("queue_empty", 16'(exp_q.size()), 16'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
